// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives imem, and registers the fetched
// word into IF/ID with stall/flush/redirect handling and a fetch counter.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_i,
  input  logic        flush_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic [31:0] imem_addr_o,
  input  logic [31:0] imem_data_i,
  output logic [31:0] if_pc_o,
  output logic [31:0] if_pc4_o,
  output logic [31:0] if_instr_o,
  output logic        if_valid_o,
  output logic        misalign_o,
  output logic [31:0] fetch_count_o
);

  localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};

  logic [31:0] pc_reg, pc_next;
  logic [31:0] ifid_pc_reg, ifid_pc_next;
  logic [31:0] ifid_pc4_reg, ifid_pc4_next;
  logic [31:0] ifid_instr_reg, ifid_instr_next;
  logic        ifid_valid_reg, ifid_valid_next;
  logic        misalign_reg, misalign_next;
  logic [31:0] fetch_count_reg, fetch_count_next;
  logic [31:0] pc_plus4;

  assign pc_plus4 = pc_reg + 32'd4;

  // Priority: redirect > flush > stall > advance.
  always_comb begin
    pc_next          = pc_reg;
    ifid_pc_next     = ifid_pc_reg;
    ifid_pc4_next    = ifid_pc4_reg;
    ifid_instr_next  = ifid_instr_reg;
    ifid_valid_next  = ifid_valid_reg;
    misalign_next    = 1'b0;
    fetch_count_next = fetch_count_reg;

    if (redirect_i) begin
      pc_next         = {redirect_pc_i[31:2], 2'b00};
      ifid_pc_next    = 32'h0;
      ifid_pc4_next   = 32'h0;
      ifid_instr_next = NOP_INSTR;
      ifid_valid_next = 1'b0;
      misalign_next   = |redirect_pc_i[1:0];
    end else if (flush_i) begin
      ifid_pc_next    = 32'h0;
      ifid_pc4_next   = 32'h0;
      ifid_instr_next = NOP_INSTR;
      ifid_valid_next = 1'b0;
    end else if (!stall_i) begin
      pc_next          = pc_plus4;
      ifid_pc_next     = pc_reg;
      ifid_pc4_next    = pc_plus4;
      ifid_instr_next  = imem_data_i;
      ifid_valid_next  = 1'b1;
      fetch_count_next = fetch_count_reg + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_reg          <= RESET_PC_ALIGNED;
      ifid_pc_reg     <= 32'h0;
      ifid_pc4_reg    <= 32'h0;
      ifid_instr_reg  <= NOP_INSTR;
      ifid_valid_reg  <= 1'b0;
      misalign_reg    <= 1'b0;
      fetch_count_reg <= 32'h0;
    end else begin
      pc_reg          <= pc_next;
      ifid_pc_reg     <= ifid_pc_next;
      ifid_pc4_reg    <= ifid_pc4_next;
      ifid_instr_reg  <= ifid_instr_next;
      ifid_valid_reg  <= ifid_valid_next;
      misalign_reg    <= misalign_next;
      fetch_count_reg <= fetch_count_next;
    end
  end

  assign imem_addr_o   = pc_reg;
  assign if_pc_o       = ifid_pc_reg;
  assign if_pc4_o      = ifid_pc4_reg;
  assign if_instr_o    = ifid_instr_reg;
  assign if_valid_o    = ifid_valid_reg;
  assign misalign_o    = misalign_reg;
  assign fetch_count_o = fetch_count_reg;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: imem returns fixed words at 0 and 4 and the
// bitwise inverse of the address elsewhere.
module tb_fetch_stage;
  logic        clk = 1'b0;
  logic        rst;
  logic        stall_i, flush_i, redirect_i;
  logic [31:0] redirect_pc_i;
  logic [31:0] imem_addr_o, imem_data_i;
  logic [31:0] if_pc_o, if_pc4_o, if_instr_o, fetch_count_o;
  logic        if_valid_o, misalign_o;
  int          errors = 0;
  int          checks = 0;

  always #5 clk = ~clk;

  always_comb begin
    if (imem_addr_o == 32'h0)      imem_data_i = 32'h0050_0093;
    else if (imem_addr_o == 32'h4) imem_data_i = 32'h00A0_0113;
    else                           imem_data_i = ~imem_addr_o;
  end

  fetch_stage dut (
    .clk(clk), .rst(rst), .stall_i(stall_i), .flush_i(flush_i),
    .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
    .imem_addr_o(imem_addr_o), .imem_data_i(imem_data_i),
    .if_pc_o(if_pc_o), .if_pc4_o(if_pc4_o), .if_instr_o(if_instr_o),
    .if_valid_o(if_valid_o), .misalign_o(misalign_o), .fetch_count_o(fetch_count_o)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; stall_i = 1'b0; flush_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = 32'h0;
    step(); step();
    checks++; if (imem_addr_o !== 32'h0) begin errors++; $display("FAIL rst_addr: got %h expected %h", imem_addr_o, 32'h0); end
    checks++; if (if_pc_o !== 32'h0) begin errors++; $display("FAIL rst_pc: got %h expected %h", if_pc_o, 32'h0); end
    checks++; if (if_pc4_o !== 32'h0) begin errors++; $display("FAIL rst_pc4: got %h expected %h", if_pc4_o, 32'h0); end
    checks++; if (if_instr_o !== 32'h13) begin errors++; $display("FAIL rst_instr: got %h expected %h", if_instr_o, 32'h13); end
    checks++; if (if_valid_o !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b expected 0", if_valid_o); end
    checks++; if (misalign_o !== 1'b0) begin errors++; $display("FAIL rst_misalign: got %b expected 0", misalign_o); end
    checks++; if (fetch_count_o !== 32'h0) begin errors++; $display("FAIL rst_count: got %h expected %h", fetch_count_o, 32'h0); end
    rst = 1'b0;
    step();
    checks++; if (if_instr_o !== 32'h0050_0093) begin errors++; $display("FAIL first_instr: got %h expected %h", if_instr_o, 32'h0050_0093); end
    checks++; if (if_pc_o !== 32'h0) begin errors++; $display("FAIL first_pc: got %h expected %h", if_pc_o, 32'h0); end
    checks++; if (if_pc4_o !== 32'h4) begin errors++; $display("FAIL first_pc4: got %h expected %h", if_pc4_o, 32'h4); end
    checks++; if (if_valid_o !== 1'b1) begin errors++; $display("FAIL first_valid: got %b expected 1", if_valid_o); end
    step();
    checks++; if (if_instr_o !== 32'h00A0_0113) begin errors++; $display("FAIL second_instr: got %h expected %h", if_instr_o, 32'h00A0_0113); end
    checks++; if (if_pc_o !== 32'h4) begin errors++; $display("FAIL second_pc: got %h expected %h", if_pc_o, 32'h4); end
    checks++; if (fetch_count_o !== 32'd2) begin errors++; $display("FAIL second_count: got %0d expected 2", fetch_count_o); end
    checks++; if (imem_addr_o !== 32'h8) begin errors++; $display("FAIL second_addr: got %h expected %h", imem_addr_o, 32'h8); end
    $display("test_reset: if_pc=%h instr=%h count=%0d", if_pc_o, if_instr_o, fetch_count_o);
  endtask

  task automatic test_stall();
    stall_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (imem_addr_o !== 32'h8) begin errors++; $display("FAIL stall_addr[%0d]: got %h expected %h", i, imem_addr_o, 32'h8); end
      checks++; if (if_pc_o !== 32'h4 || if_instr_o !== 32'h00A0_0113 || if_valid_o !== 1'b1) begin errors++; $display("FAIL stall_ifid[%0d]: got pc=%h instr=%h v=%b expected pc=4 instr=00a00113 v=1", i, if_pc_o, if_instr_o, if_valid_o); end
      checks++; if (fetch_count_o !== 32'd2) begin errors++; $display("FAIL stall_count[%0d]: got %0d expected 2", i, fetch_count_o); end
    end
    stall_i = 1'b0;
    step();
    checks++; if (if_pc_o !== 32'h8) begin errors++; $display("FAIL stall_release_pc: got %h expected %h", if_pc_o, 32'h8); end
    checks++; if (if_instr_o !== 32'hFFFF_FFF7) begin errors++; $display("FAIL stall_release_instr: got %h expected %h", if_instr_o, 32'hFFFF_FFF7); end
    checks++; if (fetch_count_o !== 32'd3) begin errors++; $display("FAIL stall_release_count: got %0d expected 3", fetch_count_o); end
    $display("test_stall: if_pc=%h count=%0d", if_pc_o, fetch_count_o);
  endtask

  task automatic test_redirect_stall();
    redirect_i = 1'b1; redirect_pc_i = 32'h40; stall_i = 1'b1;
    step();
    checks++; if (imem_addr_o !== 32'h40) begin errors++; $display("FAIL rs_addr: got %h expected %h", imem_addr_o, 32'h40); end
    checks++; if (if_valid_o !== 1'b0) begin errors++; $display("FAIL rs_valid: got %b expected 0", if_valid_o); end
    checks++; if (if_instr_o !== 32'h13) begin errors++; $display("FAIL rs_instr: got %h expected %h", if_instr_o, 32'h13); end
    checks++; if (if_pc_o !== 32'h0 || misalign_o !== 1'b0) begin errors++; $display("FAIL rs_bubble: got pc=%h mis=%b expected pc=0 mis=0", if_pc_o, misalign_o); end
    checks++; if (fetch_count_o !== 32'd3) begin errors++; $display("FAIL rs_count: got %0d expected 3", fetch_count_o); end
    redirect_i = 1'b0; stall_i = 1'b0;
    step();
    checks++; if (if_pc_o !== 32'h40) begin errors++; $display("FAIL rs_next_pc: got %h expected %h", if_pc_o, 32'h40); end
    checks++; if (if_valid_o !== 1'b1) begin errors++; $display("FAIL rs_next_valid: got %b expected 1", if_valid_o); end
    checks++; if (if_instr_o !== 32'hFFFF_FFBF) begin errors++; $display("FAIL rs_next_instr: got %h expected %h", if_instr_o, 32'hFFFF_FFBF); end
    checks++; if (fetch_count_o !== 32'd4) begin errors++; $display("FAIL rs_next_count: got %0d expected 4", fetch_count_o); end
    $display("test_redirect_stall: if_pc=%h count=%0d", if_pc_o, fetch_count_o);
  endtask

  task automatic test_misalign();
    redirect_i = 1'b1; redirect_pc_i = 32'h102;
    step();
    checks++; if (imem_addr_o !== 32'h100) begin errors++; $display("FAIL mis_addr: got %h expected %h", imem_addr_o, 32'h100); end
    checks++; if (misalign_o !== 1'b1) begin errors++; $display("FAIL mis_pulse: got %b expected 1", misalign_o); end
    redirect_i = 1'b0;
    step();
    checks++; if (misalign_o !== 1'b0) begin errors++; $display("FAIL mis_clear: got %b expected 0", misalign_o); end
    checks++; if (if_pc_o !== 32'h100 || if_instr_o !== 32'hFFFF_FEFF) begin errors++; $display("FAIL mis_fetch: got pc=%h instr=%h expected pc=00000100 instr=fffffeff", if_pc_o, if_instr_o); end
    checks++; if (fetch_count_o !== 32'd5) begin errors++; $display("FAIL mis_count: got %0d expected 5", fetch_count_o); end
    $display("test_misalign: if_pc=%h count=%0d", if_pc_o, fetch_count_o);
  endtask

  task automatic test_wrap();
    redirect_i = 1'b1; redirect_pc_i = 32'hFFFF_FFFC;
    step();
    checks++; if (imem_addr_o !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_target: got %h expected %h", imem_addr_o, 32'hFFFF_FFFC); end
    redirect_i = 1'b0;
    step();
    checks++; if (if_pc_o !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_pc: got %h expected %h", if_pc_o, 32'hFFFF_FFFC); end
    checks++; if (if_pc4_o !== 32'h0) begin errors++; $display("FAIL wrap_pc4: got %h expected %h", if_pc4_o, 32'h0); end
    checks++; if (imem_addr_o !== 32'h0) begin errors++; $display("FAIL wrap_addr: got %h expected %h", imem_addr_o, 32'h0); end
    checks++; if (if_instr_o !== 32'h3) begin errors++; $display("FAIL wrap_instr: got %h expected %h", if_instr_o, 32'h3); end
    step();
    checks++; if (if_instr_o !== 32'h0050_0093 || if_pc_o !== 32'h0) begin errors++; $display("FAIL wrap_after: got pc=%h instr=%h expected pc=0 instr=00500093", if_pc_o, if_instr_o); end
    checks++; if (fetch_count_o !== 32'd7) begin errors++; $display("FAIL wrap_count: got %0d expected 7", fetch_count_o); end
    $display("test_wrap: if_pc=%h count=%0d", if_pc_o, fetch_count_o);
  endtask

  task automatic test_flush_reset();
    redirect_i = 1'b1; redirect_pc_i = 32'h1C;
    step();
    redirect_i = 1'b0;
    step();
    checks++; if (imem_addr_o !== 32'h20 || fetch_count_o !== 32'd8) begin errors++; $display("FAIL flush_setup: got addr=%h count=%0d expected addr=00000020 count=8", imem_addr_o, fetch_count_o); end
    flush_i = 1'b1;
    step();
    checks++; if (if_valid_o !== 1'b0) begin errors++; $display("FAIL flush_valid: got %b expected 0", if_valid_o); end
    checks++; if (imem_addr_o !== 32'h20) begin errors++; $display("FAIL flush_addr: got %h expected %h", imem_addr_o, 32'h20); end
    checks++; if (if_instr_o !== 32'h13 || if_pc_o !== 32'h0) begin errors++; $display("FAIL flush_bubble: got pc=%h instr=%h expected pc=0 instr=00000013", if_pc_o, if_instr_o); end
    checks++; if (fetch_count_o !== 32'd8) begin errors++; $display("FAIL flush_count: got %0d expected 8", fetch_count_o); end
    stall_i = 1'b1;
    step();
    checks++; if (if_valid_o !== 1'b0 || imem_addr_o !== 32'h20) begin errors++; $display("FAIL flush_over_stall: got v=%b addr=%h expected v=0 addr=00000020", if_valid_o, imem_addr_o); end
    flush_i = 1'b0; stall_i = 1'b0;
    step();
    checks++; if (if_pc_o !== 32'h20 || if_valid_o !== 1'b1 || fetch_count_o !== 32'd9) begin errors++; $display("FAIL flush_refetch: got pc=%h v=%b count=%0d expected pc=00000020 v=1 count=9", if_pc_o, if_valid_o, fetch_count_o); end
    stall_i = 1'b1;
    step();
    #2 rst = 1'b1;
    #1;
    checks++; if (imem_addr_o !== 32'h0) begin errors++; $display("FAIL mid_rst_addr: got %h expected %h", imem_addr_o, 32'h0); end
    checks++; if (if_pc_o !== 32'h0 || if_pc4_o !== 32'h0) begin errors++; $display("FAIL mid_rst_pc: got pc=%h pc4=%h expected 0/0", if_pc_o, if_pc4_o); end
    checks++; if (if_instr_o !== 32'h13 || if_valid_o !== 1'b0) begin errors++; $display("FAIL mid_rst_ifid: got instr=%h v=%b expected 00000013/0", if_instr_o, if_valid_o); end
    checks++; if (fetch_count_o !== 32'h0 || misalign_o !== 1'b0) begin errors++; $display("FAIL mid_rst_count: got count=%0d mis=%b expected 0/0", fetch_count_o, misalign_o); end
    step();
    rst = 1'b0; stall_i = 1'b0;
    step();
    checks++; if (if_pc_o !== 32'h0 || if_instr_o !== 32'h0050_0093 || fetch_count_o !== 32'd1) begin errors++; $display("FAIL post_rst: got pc=%h instr=%h count=%0d expected pc=0 instr=00500093 count=1", if_pc_o, if_instr_o, fetch_count_o); end
    $display("test_flush_reset: if_pc=%h count=%0d", if_pc_o, fetch_count_o);
  endtask

  initial begin
    test_reset();
    test_stall();
    test_redirect_stall();
    test_misalign();
    test_wrap();
    test_flush_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
